// File: rtl/reorder_buffer_pkg.sv
// Shared types and default sizes for the reorder buffer.
//   rob_entry_t : one ROB slot (state bits, destination, result, redirect target)
//   ROB_*       : default parameter values used by the interface and the top
package reorder_buffer_pkg;

  localparam int ROB_DEPTH        = 16;
  localparam int ROB_DATA_W       = 64;
  localparam int ROB_MULTI_ISSUE  = 2;
  localparam int ROB_COMMIT_WIDTH = 2;
  localparam int ROB_RD_W         = 5;

  // Value and pc are stored at ROB_DATA_W; narrower DATA_WIDTH instances
  // zero-extend on write and truncate on read.
  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic                  has_rd;
    logic [ROB_RD_W-1:0]   rd;
    logic                  redirect;
    logic [ROB_DATA_W-1:0] value;
    logic [ROB_DATA_W-1:0] pc;
  } rob_entry_t;

  // Width of a "how many of N" count that must also represent N itself.
  function automatic int rob_cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Issue / completion / commit bus of the reorder buffer.
//   master : issue stage, result broadcast and commit consumer side (drives *_i)
//   slave  : the reorder buffer itself (drives *_o)
// Allocation: alloc_cnt_i, alloc_has_rd_i, alloc_rd_i -> alloc_tag_o, free_cnt_o, overflow_o
// Completion: cmpl_valid_i, cmpl_tag_i, cmpl_value_i, cmpl_redirect_i, cmpl_pc_i
// Commit:     commit_cnt_o, commit_has_rd_o, commit_rd_o, commit_value_o, flush_o, flush_pc_o, empty_o
interface reorder_buffer_if
  import reorder_buffer_pkg::*;
#(
  parameter int DATA_WIDTH   = ROB_DATA_W,
  parameter int DEPTH        = ROB_DEPTH,
  parameter int MULTI_ISSUE  = ROB_MULTI_ISSUE,
  parameter int COMMIT_WIDTH = ROB_COMMIT_WIDTH
);

  localparam int TAG_W = $clog2(DEPTH);
  localparam int AC_W  = $clog2(MULTI_ISSUE) + 1;
  localparam int CC_W  = $clog2(COMMIT_WIDTH) + 1;

  logic [AC_W-1:0]                         alloc_cnt_i;
  logic [MULTI_ISSUE-1:0]                  alloc_has_rd_i;
  logic [MULTI_ISSUE-1:0][ROB_RD_W-1:0]    alloc_rd_i;
  logic [MULTI_ISSUE-1:0][TAG_W-1:0]       alloc_tag_o;
  logic [TAG_W:0]                          free_cnt_o;
  logic                                    overflow_o;

  logic                                    cmpl_valid_i;
  logic [TAG_W-1:0]                        cmpl_tag_i;
  logic [DATA_WIDTH-1:0]                   cmpl_value_i;
  logic                                    cmpl_redirect_i;
  logic [DATA_WIDTH-1:0]                   cmpl_pc_i;

  logic [CC_W-1:0]                         commit_cnt_o;
  logic [COMMIT_WIDTH-1:0]                 commit_has_rd_o;
  logic [COMMIT_WIDTH-1:0][ROB_RD_W-1:0]   commit_rd_o;
  logic [COMMIT_WIDTH-1:0][DATA_WIDTH-1:0] commit_value_o;
  logic                                    flush_o;
  logic [DATA_WIDTH-1:0]                   flush_pc_o;
  logic                                    empty_o;

  modport master (
    output alloc_cnt_i, alloc_has_rd_i, alloc_rd_i,
    output cmpl_valid_i, cmpl_tag_i, cmpl_value_i, cmpl_redirect_i, cmpl_pc_i,
    input  alloc_tag_o, free_cnt_o, overflow_o,
    input  commit_cnt_o, commit_has_rd_o, commit_rd_o, commit_value_o,
    input  flush_o, flush_pc_o, empty_o
  );

  modport slave (
    input  alloc_cnt_i, alloc_has_rd_i, alloc_rd_i,
    input  cmpl_valid_i, cmpl_tag_i, cmpl_value_i, cmpl_redirect_i, cmpl_pc_i,
    output alloc_tag_o, free_cnt_o, overflow_o,
    output commit_cnt_o, commit_has_rd_o, commit_rd_o, commit_value_o,
    output flush_o, flush_pc_o, empty_o
  );

endinterface

// File: rtl/reorder_buffer_commit_select.sv
// rob_commit_select: combinational prefix scan picking how many of the oldest
// entries retire this cycle.
//   valid_i/done_i/redirect_i : head-relative state of the COMMIT_WIDTH oldest slots
//   commit_cnt_o              : number of lanes retiring (contiguous from lane 0)
//   flush_o                   : the last retiring lane carries a redirect
module rob_commit_select #(
  parameter int COMMIT_WIDTH = 2,
  parameter int CC_W         = $clog2(COMMIT_WIDTH) + 1
) (
  input  logic [COMMIT_WIDTH-1:0] valid_i,
  input  logic [COMMIT_WIDTH-1:0] done_i,
  input  logic [COMMIT_WIDTH-1:0] redirect_i,
  output logic [CC_W-1:0]         commit_cnt_o,
  output logic                    flush_o
);

  logic open_s;

  // Scan from the head: a lane retires only while every older lane retired
  // and none of them redirected; a redirecting lane closes the window.
  always_comb begin
    commit_cnt_o = {CC_W{1'b0}};
    flush_o      = 1'b0;
    open_s       = 1'b1;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      if (open_s && valid_i[k] && done_i[k]) begin
        commit_cnt_o = CC_W'(k + 1);
        flush_o      = redirect_i[k];
        open_s       = ~redirect_i[k];
      end else begin
        open_s = 1'b0;
      end
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order retirement queue.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, drops every entry
//   bus   : reorder_buffer_if.slave (allocate, complete, commit, flush)
// Pointers carry one extra wrap bit so full (count == DEPTH) and empty differ.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int DATA_WIDTH   = ROB_DATA_W,
  parameter int DEPTH        = ROB_DEPTH,
  parameter int MULTI_ISSUE  = ROB_MULTI_ISSUE,
  parameter int COMMIT_WIDTH = ROB_COMMIT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  reorder_buffer_if.slave  bus
);

  localparam int TAG_W = $clog2(DEPTH);
  localparam int PTR_W = TAG_W + 1;
  localparam int AC_W  = rob_cnt_width(MULTI_ISSUE);
  localparam int CC_W  = rob_cnt_width(COMMIT_WIDTH);

  rob_entry_t             rob_q [DEPTH];
  rob_entry_t             rob_d [DEPTH];
  logic [PTR_W-1:0]       head_q, head_d;
  logic [PTR_W-1:0]       tail_q, tail_d;
  logic                   overflow_q, overflow_d;

  logic [PTR_W-1:0]       count_s;
  logic [PTR_W-1:0]       free_s;
  logic                   alloc_ok_s;
  logic [MULTI_ISSUE-1:0] alloc_lane_s;
  logic [TAG_W-1:0]       alloc_idx_s  [MULTI_ISSUE];
  logic                   cmpl_hit_s;
  logic [TAG_W-1:0]       commit_idx_s [COMMIT_WIDTH];
  logic [COMMIT_WIDTH-1:0] win_valid_s, win_done_s, win_redirect_s;
  logic [COMMIT_WIDTH-1:0] commit_lane_s;
  logic [CC_W-1:0]        commit_cnt_s;
  logic                   flush_s;
  logic [TAG_W-1:0]       last_idx_s;

  // Occupancy, allocation acceptance and per-lane slot indices.
  always_comb begin
    count_s    = tail_q - head_q;
    free_s     = PTR_W'(DEPTH) - count_s;
    alloc_ok_s = (bus.alloc_cnt_i <= AC_W'(MULTI_ISSUE)) &&
                 (PTR_W'(bus.alloc_cnt_i) <= free_s);
    for (int i = 0; i < MULTI_ISSUE; i++) begin
      alloc_idx_s[i]  = TAG_W'(tail_q + PTR_W'(i));
      alloc_lane_s[i] = AC_W'(i) < bus.alloc_cnt_i;
    end
    // Completion only lands on a live entry that has not finished yet.
    cmpl_hit_s = bus.cmpl_valid_i && rob_q[bus.cmpl_tag_i].valid &&
                 !rob_q[bus.cmpl_tag_i].done;
  end

  // Gather the head-relative commit window from registered state.
  always_comb begin
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      commit_idx_s[k]   = TAG_W'(head_q + PTR_W'(k));
      win_valid_s[k]    = rob_q[commit_idx_s[k]].valid;
      win_done_s[k]     = rob_q[commit_idx_s[k]].done;
      win_redirect_s[k] = rob_q[commit_idx_s[k]].redirect;
    end
  end

  rob_commit_select #(
    .COMMIT_WIDTH (COMMIT_WIDTH),
    .CC_W         (CC_W)
  ) u_commit_select (
    .valid_i      (win_valid_s),
    .done_i       (win_done_s),
    .redirect_i   (win_redirect_s),
    .commit_cnt_o (commit_cnt_s),
    .flush_o      (flush_s)
  );

  // Commit lane data; lanes not retiring read as zero.
  always_comb begin
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      commit_lane_s[k]       = CC_W'(k) < commit_cnt_s;
      bus.commit_has_rd_o[k] = commit_lane_s[k] & rob_q[commit_idx_s[k]].has_rd;
      bus.commit_rd_o[k]     = commit_lane_s[k] ? rob_q[commit_idx_s[k]].rd : 5'd0;
      bus.commit_value_o[k]  = commit_lane_s[k] ? DATA_WIDTH'(rob_q[commit_idx_s[k]].value)
                                                : {DATA_WIDTH{1'b0}};
    end
    last_idx_s     = TAG_W'(head_q + PTR_W'(commit_cnt_s) - PTR_W'(1));
    bus.flush_pc_o = flush_s ? DATA_WIDTH'(rob_q[last_idx_s].pc) : {DATA_WIDTH{1'b0}};
  end

  // Remaining outputs straight from registered state.
  always_comb begin
    bus.alloc_tag_o  = {MULTI_ISSUE*TAG_W{1'b0}};
    for (int i = 0; i < MULTI_ISSUE; i++) begin
      bus.alloc_tag_o[i] = alloc_idx_s[i];
    end
    bus.free_cnt_o   = free_s;
    bus.overflow_o   = overflow_q;
    bus.commit_cnt_o = commit_cnt_s;
    bus.flush_o      = flush_s;
    bus.empty_o      = (count_s == PTR_W'(0));
  end

  // Next state: retire, then either flush everything or apply completion and allocation.
  // Allocation only targets free slots and completion only non-done ones, so none of
  // these updates can collide with a retiring entry.
  always_comb begin
    rob_d      = rob_q;
    head_d     = head_q + PTR_W'(commit_cnt_s);
    tail_d     = tail_q;
    overflow_d = 1'b0;

    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      rob_d[commit_idx_s[k]].valid = rob_q[commit_idx_s[k]].valid & ~commit_lane_s[k];
      rob_d[commit_idx_s[k]].done  = rob_q[commit_idx_s[k]].done  & ~commit_lane_s[k];
    end

    if (flush_s) begin
      // Everything younger than the redirecting branch is wrong-path work.
      for (int i = 0; i < DEPTH; i++) begin
        rob_d[i].valid = 1'b0;
        rob_d[i].done  = 1'b0;
      end
      tail_d = head_d;
    end else begin
      if (cmpl_hit_s) begin
        rob_d[bus.cmpl_tag_i].done     = 1'b1;
        rob_d[bus.cmpl_tag_i].value    = ROB_DATA_W'(bus.cmpl_value_i);
        rob_d[bus.cmpl_tag_i].redirect = bus.cmpl_redirect_i;
        rob_d[bus.cmpl_tag_i].pc       = ROB_DATA_W'(bus.cmpl_pc_i);
      end else begin
        overflow_d = 1'b0;
      end

      if (alloc_ok_s) begin
        for (int i = 0; i < MULTI_ISSUE; i++) begin
          if (alloc_lane_s[i]) begin
            rob_d[alloc_idx_s[i]].valid    = 1'b1;
            rob_d[alloc_idx_s[i]].done     = 1'b0;
            rob_d[alloc_idx_s[i]].has_rd   = bus.alloc_has_rd_i[i];
            rob_d[alloc_idx_s[i]].rd       = bus.alloc_rd_i[i];
            rob_d[alloc_idx_s[i]].redirect = 1'b0;
          end else begin
            rob_d[alloc_idx_s[i]] = rob_d[alloc_idx_s[i]];
          end
        end
        tail_d = tail_q + PTR_W'(bus.alloc_cnt_i);
      end else begin
        // Whole request rejected; no lane is written.
        overflow_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous clear of the whole array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= {PTR_W{1'b0}};
      tail_q     <= {PTR_W{1'b0}};
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        rob_q[i] <= '{default: 1'b0};
      end
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      overflow_q <= overflow_d;
      for (int i = 0; i < DEPTH; i++) begin
        rob_q[i] <= rob_d[i];
      end
    end
  end

endmodule
